// File: rtl/riscv_rf_pkg.sv
// Shared defaults and types for the RV32I multi-port register file.
package riscv_rf_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  // x0 is architecturally hardwired to zero
  localparam logic [DEF_AW-1:0] REG_ZERO = '0;

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: one bit per architectural register marking a
// pending producer. Issue sets, writeback clears, flush clears everything.
module reg_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     rd_addr_i,
  input  logic                     sb_set_i,
  input  logic [AW-1:0]            sb_addr_i,
  input  logic                     sb_flush_i,
  input  logic [NUM_RD*AW-1:0]     rs_addr_i,
  output logic [NUM_RD-1:0]        rs_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: writeback clears, a new issue beats a same-cycle clear,
  // flush overrides both. x0 never becomes busy.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (we_i[w]) busy_d[rd_addr_i[w*AW +: AW]] = 1'b0;
    end
    if (sb_set_i) busy_d[sb_addr_i] = 1'b1;
    if (sb_flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Per-port busy lookup; with bypass a writeback in this cycle already
  // satisfies the consumer, so the bit is masked. A same-cycle set is not seen.
  always_comb begin
    rs_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rs_busy_o[k] = busy_q[rs_addr_i[k*AW +: AW]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (we_i[w] && (rd_addr_i[w*AW +: AW] == rs_addr_i[k*AW +: AW]))
            rs_busy_o[k] = 1'b0;
        end
      end
      if (rs_addr_i[k*AW +: AW] == '0) rs_busy_o[k] = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port RV32I integer register file with optional write-to-read bypass,
// a storage-only debug read port and a busy scoreboard for the hazard unit.
module register_file_mp
  import riscv_rf_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rs_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rs_data_o,
  output logic [NUM_RD-1:0]        rs_busy_o,
  input  logic [AW-1:0]            rs_dbg_addr_i,
  output logic [XLEN-1:0]          rs_dbg_data_o,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     rd_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic                     sb_set_i,
  input  logic [AW-1:0]            sb_addr_i,
  input  logic                     sb_flush_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [AW-1:0]   ra     [NUM_RD];
  logic [AW-1:0]   wa     [NUM_WR];
  logic [XLEN-1:0] wd     [NUM_WR];
  logic [XLEN-1:0] rd_val [NUM_RD];

  // Unpack the flat port buses into per-port views.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) ra[k] = rs_addr_i[k*AW +: AW];
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w] = rd_addr_i[w*AW +: AW];
      wd[w] = wr_data_i[w*XLEN +: XLEN];
    end
  end

  // Next storage contents: ports applied in ascending order so the highest
  // index wins on an address collision; x0 is forced back to zero.
  // NOTE: every always_comb output gets a full default first (here the old
  // contents), so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (we_i[w]) regs_d[wa[w]] = wd[w];
    end
    regs_d[0] = '0;
  end

  // Storage flops.
  // NOTE: this array must clear on reset (architectural zero state), so it is
  // built from resettable flops rather than a RAM macro; sequential state uses
  // non-blocking assignments only so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Read ports: storage, optionally overridden by same-cycle write data with
  // the same port priority as the storage update; x0 always reads zero.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_val[k] = regs_q[ra[k]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (we_i[w] && (wa[w] == ra[k])) rd_val[k] = wd[w];
        end
      end
      if (ra[k] == '0) rd_val[k] = '0;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_pack
    assign rs_data_o[k*XLEN +: XLEN] = rd_val[k];
  end

  // Debug port sees committed storage only; x0 storage is held at zero.
  assign rs_dbg_data_o = regs_q[rs_dbg_addr_i];

  reg_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we_i),
    .rd_addr_i  (rd_addr_i),
    .sb_set_i   (sb_set_i),
    .sb_addr_i  (sb_addr_i),
    .sb_flush_i (sb_flush_i),
    .rs_addr_i  (rs_addr_i),
    .rs_busy_o  (rs_busy_o)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: one bypassing and one non-bypassing instance
// share stimulus; a behavioural model of the architectural state checks both
// every cycle, and directed scenarios pin the model with literal values.
module tb_register_file_mp;
  import riscv_rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data_b, rs_data_n;
  logic [1:0]  busy_b, busy_n;
  reg_addr_t   dbg_addr;
  reg_data_t   dbg_b, dbg_n;
  logic [1:0]  we;
  logic [9:0]  rd_addr;
  logic [63:0] wr_data;
  logic        sb_set;
  reg_addr_t   sb_addr;
  logic        sb_flush;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data_b),
    .rs_busy_o(busy_b), .rs_dbg_addr_i(dbg_addr), .rs_dbg_data_o(dbg_b),
    .we_i(we), .rd_addr_i(rd_addr), .wr_data_i(wr_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .sb_flush_i(sb_flush)
  );

  register_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rs_addr_i(rs_addr), .rs_data_o(rs_data_n),
    .rs_busy_o(busy_n), .rs_dbg_addr_i(dbg_addr), .rs_dbg_data_o(dbg_n),
    .we_i(we), .rd_addr_i(rd_addr), .wr_data_i(wr_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .sb_flush_i(sb_flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic bit wr_hits(input logic [4:0] r);
    return (we[0] && rd_addr[4:0] == r) || (we[1] && rd_addr[9:5] == r);
  endfunction

  // Value an architectural read must return this cycle.
  function automatic logic [31:0] exp_rd(input logic [4:0] r, input bit byp);
    if (r == 5'd0) return 32'h0;
    if (byp && we[1] && rd_addr[9:5] == r) return wr_data[63:32];
    if (byp && we[0] && rd_addr[4:0] == r) return wr_data[31:0];
    return m_regs[r];
  endfunction

  function automatic bit exp_busy(input logic [4:0] r, input bit byp);
    if (r == 5'd0) return 1'b0;
    if (byp && wr_hits(r)) return 1'b0;
    return m_busy[r];
  endfunction

  // Architectural state update at each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = 32'h0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        bit nb;
        if (we[1] && rd_addr[9:5] == r[4:0])      m_regs[r] = wr_data[63:32];
        else if (we[0] && rd_addr[4:0] == r[4:0]) m_regs[r] = wr_data[31:0];
        if (sb_flush)                             nb = 1'b0;
        else if (sb_set && sb_addr == r[4:0])     nb = 1'b1;
        else if (wr_hits(r[4:0]))                 nb = 1'b0;
        else                                      nb = m_busy[r];
        m_busy[r] = nb;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [4:0] a;
        a = rs_addr[k*5 +: 5];
        check("model_rd_byp", rs_data_b[k*32 +: 32], exp_rd(a, 1'b1));
        check("model_rd_nobyp", rs_data_n[k*32 +: 32], exp_rd(a, 1'b0));
        check("model_busy_byp", 32'(busy_b[k]), 32'(exp_busy(a, 1'b1)));
        check("model_busy_nobyp", 32'(busy_n[k]), 32'(exp_busy(a, 1'b0)));
      end
      check("model_dbg_byp", dbg_b, m_regs[dbg_addr]);
      check("model_dbg_nobyp", dbg_n, m_regs[dbg_addr]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rst = 1'b0; we = '0; rd_addr = '0; wr_data = '0;
    sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1; rs_addr = '0; dbg_addr = '0;
    next_cycle();
    chk_en = 1'b1;
    idle();

    // Reset state on every register, every port
    for (int r = 0; r < 32; r++) begin
      rs_addr = {r[4:0], r[4:0]}; dbg_addr = r[4:0];
      @(negedge clk);
      check("rst_rd0", rs_data_b[31:0], 32'h0);
      check("rst_rd1", rs_data_b[63:32], 32'h0);
      check("rst_busy", 32'(busy_b), 32'h0);
      check("rst_dbg", dbg_b, 32'h0);
      next_cycle();
    end

    // Write in the same cycle as reset is discarded
    we = 2'b01; rd_addr = {5'd0, 5'd5}; wr_data = 64'h1234; rst = 1'b1;
    next_cycle();
    idle(); rs_addr = {5'd0, 5'd5}; dbg_addr = 5'd5;
    @(negedge clk);
    check("wr_rst_rd", rs_data_n[31:0], 32'h0);
    check("wr_rst_dbg", dbg_b, 32'h0);
    next_cycle();

    // Bypass vs. storage-only visibility
    we = 2'b01; rd_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF}; rs_addr = {5'd0, 5'd5};
    @(negedge clk);
    check("byp_same_cycle", rs_data_b[31:0], 32'hDEADBEEF);
    check("nobyp_same_cycle", rs_data_n[31:0], 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("nobyp_next_cycle", rs_data_n[31:0], 32'hDEADBEEF);
    next_cycle();

    // Two ports to one address: port 1 wins
    we = 2'b11; rd_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rs_addr = {5'd7, 5'd7};
    @(negedge clk);
    check("prio_rd0", rs_data_b[31:0], 32'h22);
    check("prio_rd1", rs_data_b[63:32], 32'h22);
    next_cycle();
    idle(); dbg_addr = 5'd7;
    @(negedge clk);
    check("prio_dbg", dbg_b, 32'h22);
    check("prio_dbg_nobyp", dbg_n, 32'h22);
    next_cycle();

    // x0 ignores writes and sets
    we = 2'b01; rd_addr = '0; wr_data = {32'h0, 32'hFFFFFFFF};
    sb_set = 1'b1; sb_addr = 5'd0; rs_addr = '0;
    @(negedge clk);
    check("x0_rd", rs_data_b[31:0], 32'h0);
    check("x0_busy", 32'(busy_b[0]), 32'h0);
    next_cycle();
    idle(); dbg_addr = 5'd0;
    @(negedge clk);
    check("x0_dbg", dbg_b, 32'h0);
    check("x0_busy_next", 32'(busy_b[0]), 32'h0);
    next_cycle();

    // Set x3, two busy cycles, then writeback clears with bypass
    sb_set = 1'b1; sb_addr = 5'd3; rs_addr = {5'd3, 5'd3};
    @(negedge clk);
    check("set_not_fwd", 32'(busy_b[0]), 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("busy_cyc1", 32'(busy_b[0]), 32'h1);
    next_cycle();
    @(negedge clk);
    check("busy_cyc2", 32'(busy_b[1]), 32'h1);
    next_cycle();
    we = 2'b01; rd_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55};
    @(negedge clk);
    check("wb_busy_byp", 32'(busy_b[0]), 32'h0);
    check("wb_busy_nobyp", 32'(busy_n[0]), 32'h1);
    check("wb_data", rs_data_b[31:0], 32'h55);
    next_cycle();
    idle();
    @(negedge clk);
    check("after_wb_busy", 32'(busy_n[0]), 32'h0);
    check("after_wb_data", rs_data_n[31:0], 32'h55);
    next_cycle();

    // Set beats same-cycle clear; flush clears
    sb_set = 1'b1; sb_addr = 5'd9; we = 2'b10; rd_addr = {5'd9, 5'd0};
    wr_data = {32'h99, 32'h0}; rs_addr = {5'd9, 5'd9};
    next_cycle();
    idle();
    @(negedge clk);
    check("set_wins", 32'(busy_b[0]), 32'h1);
    next_cycle();
    sb_flush = 1'b1;
    @(negedge clk);
    check("flush_not_fwd", 32'(busy_b[1]), 32'h1);
    next_cycle();
    idle();
    @(negedge clk);
    check("flush_busy", 32'(busy_b[0]), 32'h0);
    check("flush_keeps_data", rs_data_b[31:0], 32'h99);
    next_cycle();

    // Randomized multi-port traffic
    for (int c = 0; c < 10000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      we       = 2'($urandom_range(0, 3));
      rd_addr  = {rnd_addr(), rnd_addr()};
      wr_data  = {$urandom(), $urandom()};
      sb_set   = ($urandom_range(0, 2) == 0);
      sb_addr  = rnd_addr();
      sb_flush = ($urandom_range(0, 63) == 0);
      rs_addr  = {rnd_addr(), rnd_addr()};
      dbg_addr = rnd_addr();
      @(negedge clk);
      next_cycle();
    end

    idle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
